timebase_gen: RTL and testbench
===============================

Name: timebase_gen

Overview:
- Shared timing and input-conditioning stage for the DE2 display and LED pattern blocks. Feeds the HEX, LEDG and LEDR sequencers.
- Replaces per-block ripple-divided clocks with single-cycle tick enables in the CK domain.
- Also produces a debounced, synchronized copy of the mode switch and a 0–59 seconds count.
- All outputs are registered in the CK domain.

Parameters:
- P_1S, 50000000, cycles between tick_1s pulses (1 s at 50 MHz)
- P_500MS, 25000000, cycles between tick_500ms pulses
- P_200MS, 10000000, cycles between tick_200ms pulses
- DEB_CYC, 1000000, consecutive mismatching cycles required before sw_db changes (20 ms)
- CW, 26, width of divider and debounce counters; must satisfy 2^CW > max(P_*, DEB_CYC)

Ports:
- CK  input  1  system clock (CLOCK_50)
- RS  input  1  reset; synchronous, active-high
- EN  input  1  divider run enable; low freezes the tick dividers and sec_cnt
- SW_IN  input  1  raw asynchronous switch
- tick_1s  output  1  one-cycle pulse every P_1S enabled cycles
- tick_500ms  output  1  one-cycle pulse every P_500MS enabled cycles
- tick_200ms  output  1  one-cycle pulse every P_200MS enabled cycles
- sec_cnt  output  6  seconds counter, 0..59
- sw_db  output  1  debounced switch level
- sw_rise  output  1  one-cycle pulse when sw_db goes 0→1
- sw_fall  output  1  one-cycle pulse when sw_db goes 1→0

Behaviour:
- Reset: on a CK edge with RS=1, all of the following clear to 0 on that edge:
  - divider counters, all ticks, sec_cnt
  - sync flops sw_s1 and sw_s2, sw_db, debounce counter, sw_rise, sw_fall
- RS dominates EN and SW_IN. Reset mid-count discards any partial count; no tick is emitted on the reset edge.
- Dividers: three independent CW-bit counters, each with its own period P.
  - On an edge with EN=1: if cnt==P-1, then cnt←0 and the tick is registered as 1; otherwise cnt←cnt+1 and the tick is 0.
  - First tick is high in the cycle following the P-th enabled edge after reset release. Ticks are exactly P enabled cycles apart thereafter.
- EN=0: counters and sec_cnt hold; ticks are forced 0. Counting resumes from the held value, so no tick is lost or duplicated, only delayed.
- Coincidence: ticks are independent. With defaults, all three assert in the same cycle every 50M cycles. Consumers must accept simultaneous ticks.
- sec_cnt: increments on the edge where tick_1s is generated, so its new value is visible in the same cycle tick_1s is high. It wraps 59→0 and never shows 60..63.
- Synchronizer: sw_s1←SW_IN, sw_s2←sw_s1 on every edge, independent of EN.
- Debounce:
  - If sw_s2 != sw_db, dcnt←dcnt+1; if sw_s2 == sw_db, dcnt←0.
  - When sw_s2 != sw_db and dcnt==DEB_CYC-1: sw_db←sw_s2, dcnt←0.
  - Latency from a clean SW_IN step to the sw_db change is DEB_CYC+2 edges.
  - A glitch shorter than DEB_CYC cycles at sw_s2 never changes sw_db; any single matching cycle restarts the count.
  - Debounce is independent of EN.
- Edge pulses: sw_rise and sw_fall are registered. Each is high for exactly the one cycle in which sw_db shows its new value, and they are never both high.
- Parameter rules: P_* ≥ 2 and DEB_CYC ≥ 2. Violations are caught by a simulation-time assertion, not by hardware.

Test Plan (sim overrides: P_1S=10, P_500MS=5, P_200MS=2, DEB_CYC=4):
- Reset, EN=1, SW_IN=0, run 40 cycles.
  - tick_200ms high at cycles 2,4,6,…; tick_500ms at 5,10,…; tick_1s at 10,20,30,40.
  - sec_cnt reads 1,2,3,4 in the tick_1s cycles; all three ticks high together at cycles 10,20,30,40.
- Run 600+ cycles: sec_cnt reaches 59, then reads 0 in the cycle of the 60th tick_1s.
- EN=1 for 7 cycles, EN=0 for 20 cycles, EN=1 again.
  - No ticks while EN=0.
  - Next tick_1s arrives after 3 further enabled cycles; tick_500ms after 3; tick_200ms after 1.
- Reset pulse asserted at cycle 7 of a count: all outputs 0 on that edge; the next tick_1s comes 10 enabled cycles after RS falls.
- SW_IN 0→1 held steady: sw_db rises at edge 6 after the step, with sw_rise high for that one cycle only. A later 1→0 step gives sw_fall symmetrically.
- SW_IN pulses of 1, 2 and 3 cycles separated by 1-cycle lows: sw_db stays 0, sw_rise never asserts. A 4-cycle-stable pulse then does flip sw_db.

Source files
------------

// File: rtl/timebase_gen.sv
`default_nettype none
// ============================================================================
// Module   : timebase_gen
// Purpose  : Shared timebase for the DE2 display/LED sequencers. Generates
//            single-cycle tick enables (1 s, 500 ms, 200 ms), a 0..59 seconds
//            count, and a synchronized, debounced mode switch with edge
//            pulses. Everything is registered in the CK domain.
// Revision : 1.0 - initial release
// ============================================================================
module timebase_gen #(
    parameter int unsigned P_1S    = 50000000,
    parameter int unsigned P_500MS = 25000000,
    parameter int unsigned P_200MS = 10000000,
    parameter int unsigned DEB_CYC = 1000000,
    parameter int unsigned CW      = 26
) (
    input  logic       CK,
    input  logic       RS,
    input  logic       EN,
    input  logic       SW_IN,
    output logic       tick_1s,
    output logic       tick_500ms,
    output logic       tick_200ms,
    output logic [5:0] sec_cnt,
    output logic       sw_db,
    output logic       sw_rise,
    output logic       sw_fall
);

    localparam int unsigned    NDIV     = 3;
    localparam logic [CW-1:0]  DEB_LAST = CW'(DEB_CYC - 1);
    localparam logic [5:0]     SEC_LAST = 6'd59;

    // Index 0 = 1 s, 1 = 500 ms, 2 = 200 ms.
    logic [NDIV-1:0] div_tick;   // registered tick of each divider
    logic [NDIV-1:0] div_wrap;   // this edge completes a period (tick next cycle)

    // ------------------------------------------------------------------------
    // Tick dividers: one free-running counter per period, frozen when EN=0.
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < NDIV; g++) begin : g_div
        localparam int unsigned   PER    = (g == 0) ? P_1S :
                                           (g == 1) ? P_500MS : P_200MS;
        localparam logic [CW-1:0] C_LAST = CW'(PER - 1);

        logic [CW-1:0] cnt_q;
        logic          tick_q;

        assign div_wrap[g] = EN && (cnt_q == C_LAST);
        assign div_tick[g] = tick_q;

        // Count enabled cycles; the tick is a registered copy of the wrap.
        always_ff @(posedge CK) begin
            if (RS) begin
                cnt_q  <= '0;
                tick_q <= 1'b0;
            end else if (EN) begin
                if (cnt_q == C_LAST) begin
                    cnt_q  <= '0;
                    tick_q <= 1'b1;
                end else begin
                    cnt_q  <= cnt_q + 1'b1;
                    tick_q <= 1'b0;
                end
            end else begin
                tick_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Seconds counter: advances on the same edge that raises tick_1s, so the
    // new value and the tick appear together.
    // ------------------------------------------------------------------------
    logic [5:0] sec_q;

    // Modulo-60 count of 1 s wraps.
    always_ff @(posedge CK) begin
        if (RS) begin
            sec_q <= '0;
        end else if (div_wrap[0]) begin
            sec_q <= (sec_q == SEC_LAST) ? 6'd0 : sec_q + 6'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Switch conditioning: 2-flop synchronizer followed by a debounce counter
    // that needs DEB_CYC consecutive disagreeing samples before sw_db moves.
    // ------------------------------------------------------------------------
    logic          sw_s1_q;
    logic          sw_s2_q;
    logic          sw_db_q;
    logic [CW-1:0] dcnt_q;
    logic          sw_rise_q;
    logic          sw_fall_q;

    // Synchronize, debounce and flag the edge of the accepted level.
    always_ff @(posedge CK) begin
        if (RS) begin
            sw_s1_q   <= 1'b0;
            sw_s2_q   <= 1'b0;
            sw_db_q   <= 1'b0;
            dcnt_q    <= '0;
            sw_rise_q <= 1'b0;
            sw_fall_q <= 1'b0;
        end else begin
            sw_s1_q   <= SW_IN;
            sw_s2_q   <= sw_s1_q;
            sw_rise_q <= 1'b0;
            sw_fall_q <= 1'b0;
            if (sw_s2_q != sw_db_q) begin
                if (dcnt_q == DEB_LAST) begin
                    sw_db_q   <= sw_s2_q;
                    dcnt_q    <= '0;
                    sw_rise_q <= sw_s2_q;
                    sw_fall_q <= ~sw_s2_q;
                end else begin
                    dcnt_q <= dcnt_q + 1'b1;
                end
            end else begin
                // Any agreeing sample restarts the stability window.
                dcnt_q <= '0;
            end
        end
    end

    // Parameter sanity: a period or debounce length below 2 is meaningless.
    always @(posedge CK) begin
        assert (P_1S >= 2 && P_500MS >= 2 && P_200MS >= 2 && DEB_CYC >= 2);
    end

    assign tick_1s    = div_tick[0];
    assign tick_500ms = div_tick[1];
    assign tick_200ms = div_tick[2];
    assign sec_cnt    = sec_q;
    assign sw_db      = sw_db_q;
    assign sw_rise    = sw_rise_q;
    assign sw_fall    = sw_fall_q;

endmodule
`default_nettype wire

// File: tb/tb_timebase_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_timebase_gen
// Purpose  : Self-checking bench for timebase_gen with short periods.
//            A reference model derived from enabled-cycle counts and a
//            sliding window of synchronized switch samples predicts every
//            output each cycle; directed checks pin down the key latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timebase_gen;

    localparam int P1  = 10;
    localparam int P5  = 5;
    localparam int P2  = 2;
    localparam int DEB = 4;

    logic       CK = 1'b0;
    logic       RS;
    logic       EN;
    logic       SW_IN;
    logic       tick_1s;
    logic       tick_500ms;
    logic       tick_200ms;
    logic [5:0] sec_cnt;
    logic       sw_db;
    logic       sw_rise;
    logic       sw_fall;

    timebase_gen #(
        .P_1S    (P1),
        .P_500MS (P5),
        .P_200MS (P2),
        .DEB_CYC (DEB),
        .CW      (26)
    ) dut (
        .CK         (CK),
        .RS         (RS),
        .EN         (EN),
        .SW_IN      (SW_IN),
        .tick_1s    (tick_1s),
        .tick_500ms (tick_500ms),
        .tick_200ms (tick_200ms),
        .sec_cnt    (sec_cnt),
        .sw_db      (sw_db),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall)
    );

    always #5 CK = ~CK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int  en_cnt;          // enabled edges since reset
    bit  m_t1, m_t5, m_t2;
    bit  pipe[$];         // SW_IN values still inside the synchronizer
    bit  s2h[$];          // last DEB synchronized samples seen by the debouncer
    bit  m_db, m_rise, m_fall;
    bit  seen_rise;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rs, input bit en, input bit sw);
        bit s2;
        bit all_diff;
        if (rs) begin
            en_cnt = 0;
            m_t1 = 0; m_t5 = 0; m_t2 = 0;
            pipe = {1'b0, 1'b0};
            s2h  = {};
            m_db = 0; m_rise = 0; m_fall = 0;
        end else begin
            if (en) begin
                en_cnt++;
                m_t1 = (en_cnt % P1 == 0);
                m_t5 = (en_cnt % P5 == 0);
                m_t2 = (en_cnt % P2 == 0);
            end else begin
                m_t1 = 0; m_t5 = 0; m_t2 = 0;
            end
            s2 = pipe.pop_front();
            pipe.push_back(sw);
            s2h.push_back(s2);
            if (s2h.size() > DEB) void'(s2h.pop_front());
            m_rise = 0;
            m_fall = 0;
            all_diff = (s2h.size() == DEB);
            foreach (s2h[i]) if (s2h[i] == m_db) all_diff = 0;
            if (all_diff) begin
                m_db   = ~m_db;
                m_rise = m_db;
                m_fall = ~m_db;
            end
        end
    endtask

    // Apply inputs for one edge, advance the model, compare just after the edge.
    task automatic step(input bit rs, input bit en, input bit sw);
        RS = rs; EN = en; SW_IN = sw;
        @(posedge CK);
        model_edge(rs, en, sw);
        #1;
        chk("tick_1s",    tick_1s,    m_t1);
        chk("tick_500ms", tick_500ms, m_t5);
        chk("tick_200ms", tick_200ms, m_t2);
        chk("sec_cnt",    sec_cnt,    (en_cnt / P1) % 60);
        chk("sw_db",      sw_db,      m_db);
        chk("sw_rise",    sw_rise,    m_rise);
        chk("sw_fall",    sw_fall,    m_fall);
        if (sw_rise === 1'b1) seen_rise = 1;
    endtask

    initial begin
        bit sw;
        RS = 1'b1; EN = 1'b0; SW_IN = 1'b0;

        // Reset and basic tick cadence
        step(1, 1, 0);
        step(1, 1, 0);
        for (int c = 1; c <= 600; c++) begin
            step(0, 1, 0);
            if (c == 10) chk("first_tick_1s_sec", sec_cnt, 1);
            if (c == 40) begin
                chk("all_ticks_c40", {tick_1s, tick_500ms, tick_200ms}, 3'b111);
                chk("sec_c40", sec_cnt, 4);
            end
            if (c == 590) chk("sec_59", sec_cnt, 59);
            if (c == 600) begin
                chk("sec_wrap_tick", tick_1s, 1);
                chk("sec_wrap_val",  sec_cnt, 0);
            end
        end

        // EN freeze: 7 enabled, 20 disabled, then resume
        step(1, 1, 0);
        for (int c = 0; c < 7; c++)  step(0, 1, 0);
        for (int c = 0; c < 20; c++) step(0, 0, 0);
        step(0, 1, 0);
        chk("resume_200ms_after1", tick_200ms, 1);
        step(0, 1, 0);
        step(0, 1, 0);
        chk("resume_1s_after3",    tick_1s,    1);
        chk("resume_500ms_after3", tick_500ms, 1);

        // Reset in the middle of a count
        step(1, 1, 0);
        for (int c = 0; c < 7; c++) step(0, 1, 0);
        step(1, 1, 0);
        chk("midreset_outputs", {tick_1s, tick_500ms, tick_200ms, sec_cnt}, 0);
        for (int c = 1; c <= 10; c++) begin
            step(0, 1, 0);
            if (c == 9)  chk("midreset_no_early_1s", tick_1s, 0);
            if (c == 10) chk("midreset_1s_after10",  tick_1s, 1);
        end

        // Clean switch steps
        step(1, 1, 0);
        for (int k = 1; k <= 10; k++) begin
            step(0, 1, 1);
            if (k == 5) chk("rise_not_before6", sw_db, 0);
            if (k == 6) chk("rise_at6", {sw_db, sw_rise, sw_fall}, 3'b110);
            if (k == 7) chk("rise_one_cycle", sw_rise, 0);
        end
        for (int k = 1; k <= 10; k++) begin
            step(0, 1, 0);
            if (k == 6) chk("fall_at6", {sw_db, sw_rise, sw_fall}, 3'b001);
            if (k == 7) chk("fall_one_cycle", sw_fall, 0);
        end

        // Short glitches never pass; a 4-cycle pulse does
        step(1, 1, 0);
        step(0, 1, 0);
        seen_rise = 0;
        step(0, 1, 1); step(0, 1, 0);
        step(0, 1, 1); step(0, 1, 1); step(0, 1, 0);
        step(0, 1, 1); step(0, 1, 1); step(0, 1, 1); step(0, 1, 0);
        for (int k = 0; k < 6; k++) step(0, 1, 0);
        chk("glitch_no_rise", seen_rise, 0);
        chk("glitch_db_low",  sw_db, 0);
        for (int k = 0; k < 4; k++) step(0, 1, 1);
        for (int k = 0; k < 3; k++) step(0, 1, 0);
        chk("pulse4_rise", seen_rise, 1);

        // Randomized traffic against the model
        sw = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 3) == 0) sw = ~sw;
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0), sw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
